// File: rtl/structs_pkg.sv
// Shared issue-stage types: scheduler view of an RS entry, branch/ALU encodings,
// and the internal reservation-station entry/operand records.
package structs_pkg;

  localparam int RS_ENTRIES = 4;
  localparam int ROB_TAG_W  = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef enum logic [2:0] {
    NB   = 3'd0,
    BEQ  = 3'd1,
    BNE  = 3'd2,
    BLT  = 3'd3,
    BGE  = 3'd4,
    BLTU = 3'd5,
    BGEU = 3'd6,
    JMP  = 3'd7
  } branch_type_t;

  typedef struct packed {
    logic                 valid_operands;
    logic [3:0]           ALU_op;
    logic                 load;
    branch_type_t         branch_type;
    logic [ROB_TAG_W-1:0] ROB_entry;
    logic [31:0]          rs1;
    logic [31:0]          rs2;
  } rs_out_t;

  typedef struct packed {
    logic                 rdy;
    logic [ROB_TAG_W-1:0] tag;
    logic [31:0]          val;
  } rs_operand_t;

  // Control part of an entry; the two operands live in rs_operand_snoop instances.
  typedef struct packed {
    logic                 busy;
    logic [3:0]           ALU_op;
    logic                 load;
    branch_type_t         branch_type;
    logic [ROB_TAG_W-1:0] ROB_entry;
  } rs_entry_t;

endpackage

// File: rtl/rs_operand_snoop.sv
// One source operand of a reservation-station entry: holds rdy/tag/value, captures
// from the CDB while waiting, and bypasses a same-cycle broadcast at dispatch.
module rs_operand_snoop
  import structs_pkg::*;
#(
  parameter int NUM_CDB = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               load_en,
  input  logic                               capture_en,
  input  logic                               disp_rdy,
  input  logic [31:0]                        disp_val,
  input  logic [ROB_TAG_W-1:0]               disp_tag,
  input  logic [NUM_CDB-1:0]                 cdb_valid,
  input  logic [NUM_CDB-1:0][ROB_TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB-1:0][31:0]           cdb_val,
  output logic                               rdy,
  output logic [31:0]                        val
);

  rs_operand_t op_q;
  logic        disp_hit;
  logic        snoop_hit;
  logic [31:0] disp_hit_val;
  logic [31:0] snoop_hit_val;

  // Scan from the top port down so the lowest matching port is the one that sticks.
  always_comb begin
    disp_hit      = 1'b0;
    disp_hit_val  = '0;
    snoop_hit     = 1'b0;
    snoop_hit_val = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_tag[p] == disp_tag)) begin
        disp_hit     = 1'b1;
        disp_hit_val = cdb_val[p];
      end
      if (cdb_valid[p] && (cdb_tag[p] == op_q.tag)) begin
        snoop_hit     = 1'b1;
        snoop_hit_val = cdb_val[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      op_q <= '0;
    end else if (load_en) begin
      op_q.rdy <= disp_rdy | disp_hit;
      op_q.tag <= disp_tag;
      op_q.val <= disp_rdy ? disp_val : disp_hit_val;
    end else if (capture_en && !op_q.rdy && snoop_hit) begin
      op_q.rdy <= 1'b1;
      op_q.val <= snoop_hit_val;
    end
  end

  assign rdy = op_q.rdy;
  assign val = op_q.val;

endmodule

// File: rtl/rs_bank.sv
// Four-entry reservation-station bank feeding the FU scheduler.
// Optional RS_PERF_CNT_EN adds full-stall and issue performance counters.
module rs_bank
  import structs_pkg::*;
#(
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [3:0]                     disp_ALU_op,
  input  logic                           disp_load,
  input  branch_type_t                   disp_branch_type,
  input  logic [TAG_W-1:0]               disp_ROB_entry,
  input  logic                           disp_rs1_rdy,
  input  logic [31:0]                    disp_rs1_val,
  input  logic [TAG_W-1:0]               disp_rs1_tag,
  input  logic                           disp_rs2_rdy,
  input  logic [31:0]                    disp_rs2_val,
  input  logic [TAG_W-1:0]               disp_rs2_tag,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB-1:0][TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB-1:0][31:0]       cdb_val,
  input  logic [RS_ENTRIES-1:0]          consumed_bus,
  output rs_out_t [RS_ENTRIES-1:0]       rs_data
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_full_stall,
  output logic [31:0]                    perf_issue
`endif
);

  rs_entry_t             ent_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] busy;
  logic [RS_ENTRIES-1:0] alloc;
  logic [RS_ENTRIES-1:0] capture_en;
  logic [RS_ENTRIES-1:0] op1_rdy;
  logic [RS_ENTRIES-1:0] op2_rdy;
  logic [31:0]           op1_val [RS_ENTRIES];
  logic [31:0]           op2_val [RS_ENTRIES];

  // Allocation works off the pre-edge busy mask, so a slot freed this cycle waits one cycle.
  always_comb begin
    busy  = '0;
    alloc = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      busy[i] = ent_q[i].busy;
    end
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc    = '0;
        alloc[i] = disp_valid;
      end
    end
  end

  assign disp_ready = ~&busy;
  assign capture_en = busy & ~consumed_bus;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (alloc[i]) begin
          ent_q[i] <= '{busy: 1'b1, ALU_op: disp_ALU_op, load: disp_load,
                        branch_type: disp_branch_type, ROB_entry: disp_ROB_entry};
        end else if (consumed_bus[i]) begin
          ent_q[i].busy <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < RS_ENTRIES; i++) begin : g_entry
    rs_operand_snoop #(.NUM_CDB(NUM_CDB)) u_op1 (
      .clk        (clk),
      .reset      (reset),
      .clear      (flush),
      .load_en    (alloc[i]),
      .capture_en (capture_en[i]),
      .disp_rdy   (disp_rs1_rdy),
      .disp_val   (disp_rs1_val),
      .disp_tag   (disp_rs1_tag),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_val    (cdb_val),
      .rdy        (op1_rdy[i]),
      .val        (op1_val[i])
    );

    rs_operand_snoop #(.NUM_CDB(NUM_CDB)) u_op2 (
      .clk        (clk),
      .reset      (reset),
      .clear      (flush),
      .load_en    (alloc[i]),
      .capture_en (capture_en[i]),
      .disp_rdy   (disp_rs2_rdy),
      .disp_val   (disp_rs2_val),
      .disp_tag   (disp_rs2_tag),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_val    (cdb_val),
      .rdy        (op2_rdy[i]),
      .val        (op2_val[i])
    );

    assign rs_data[i] = '{valid_operands: busy[i] & op1_rdy[i] & op2_rdy[i],
                          ALU_op:         ent_q[i].ALU_op,
                          load:           ent_q[i].load,
                          branch_type:    ent_q[i].branch_type,
                          ROB_entry:      ent_q[i].ROB_entry,
                          rs1:            op1_val[i],
                          rs2:            op2_val[i]};
  end

`ifdef RS_PERF_CNT_EN
  // Counters survive flush so they reflect the whole run, not just the current path.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_full_stall <= '0;
      perf_issue      <= '0;
    end else begin
      if (disp_valid && !disp_ready) begin
        perf_full_stall <= perf_full_stall + 32'd1;
      end
      perf_issue <= perf_issue + 32'($countones(consumed_bus & busy));
    end
  end
`endif

endmodule

// File: tb/tb_rs_bank.sv
// Directed self-checking bench for rs_bank; perf counter checks compile in
// only when RS_PERF_CNT_EN is defined.
module tb_rs_bank;
  import structs_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic               disp_valid;
  logic               disp_ready;
  logic [3:0]         disp_ALU_op;
  logic               disp_load;
  branch_type_t       disp_branch_type;
  logic [3:0]         disp_ROB_entry;
  logic               disp_rs1_rdy;
  logic [31:0]        disp_rs1_val;
  logic [3:0]         disp_rs1_tag;
  logic               disp_rs2_rdy;
  logic [31:0]        disp_rs2_val;
  logic [3:0]         disp_rs2_tag;
  logic [1:0]         cdb_valid;
  logic [1:0][3:0]    cdb_tag;
  logic [1:0][31:0]   cdb_val;
  logic [3:0]         consumed_bus;
  rs_out_t [3:0]      rs_data;
`ifdef RS_PERF_CNT_EN
  logic [31:0]        perf_full_stall;
  logic [31:0]        perf_issue;
`endif

  int test_cnt = 0;
  int fail_cnt = 0;

  rs_bank #(.NUM_CDB(2), .TAG_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .disp_valid       (disp_valid),
    .disp_ready       (disp_ready),
    .disp_ALU_op      (disp_ALU_op),
    .disp_load        (disp_load),
    .disp_branch_type (disp_branch_type),
    .disp_ROB_entry   (disp_ROB_entry),
    .disp_rs1_rdy     (disp_rs1_rdy),
    .disp_rs1_val     (disp_rs1_val),
    .disp_rs1_tag     (disp_rs1_tag),
    .disp_rs2_rdy     (disp_rs2_rdy),
    .disp_rs2_val     (disp_rs2_val),
    .disp_rs2_tag     (disp_rs2_tag),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_val          (cdb_val),
    .consumed_bus     (consumed_bus),
    .rs_data          (rs_data)
`ifdef RS_PERF_CNT_EN
    ,
    .perf_full_stall  (perf_full_stall),
    .perf_issue       (perf_issue)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    reset        = 1'b0;
    flush        = 1'b0;
    disp_valid   = 1'b0;
    cdb_valid    = '0;
    consumed_bus = '0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [3:0] rob,
                          input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                          input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag);
    disp_valid       = 1'b1;
    disp_ALU_op      = op;
    disp_load        = 1'b0;
    disp_branch_type = NB;
    disp_ROB_entry   = rob;
    disp_rs1_rdy     = r1rdy;
    disp_rs1_val     = r1val;
    disp_rs1_tag     = r1tag;
    disp_rs2_rdy     = r2rdy;
    disp_rs2_val     = r2val;
    disp_rs2_tag     = r2tag;
  endtask

  task automatic test_reset;
    idle();
    set_disp(ALU_SUB, 4'd9, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    reset = 1'b1;
    tick();
    tick();
    idle();
    test_cnt++;
    if (disp_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_ready: got %b want 1", disp_ready);
    end
    for (int i = 0; i < 4; i++) begin
      test_cnt++;
      if (rs_data[i] !== '0) begin
        fail_cnt++;
        $display("FAIL reset_entry%0d: got %h want 0", i, rs_data[i]);
      end
    end
  endtask

  task automatic test_ready_dispatch;
    set_disp(ALU_ADD, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b1 || rs_data[0].rs1 !== 32'd5 ||
        rs_data[0].rs2 !== 32'd7 || rs_data[0].ROB_entry !== 4'd3 ||
        rs_data[0].ALU_op !== ALU_ADD) begin
      fail_cnt++;
      $display("FAIL ready_dispatch: got v=%b rs1=%0d rs2=%0d rob=%0d op=%0d want v=1 rs1=5 rs2=7 rob=3 op=0",
               rs_data[0].valid_operands, rs_data[0].rs1, rs_data[0].rs2,
               rs_data[0].ROB_entry, rs_data[0].ALU_op);
    end
    consumed_bus = 4'b0001;
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b0 || disp_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL consume_free: got v=%b rdy=%b want v=0 rdy=1",
               rs_data[0].valid_operands, disp_ready);
    end
  endtask

  task automatic test_cdb_wakeup;
    set_disp(ALU_ADD, 4'd5, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9);
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b0) begin
      fail_cnt++;
      $display("FAIL wakeup_wait0: got v=%b want 0", rs_data[0].valid_operands);
    end
    cdb_valid  = 2'b01;
    cdb_tag[0] = 4'd8;
    cdb_val[0] = 32'hBEEF;
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b0) begin
      fail_cnt++;
      $display("FAIL wakeup_nomatch: got v=%b want 0", rs_data[0].valid_operands);
    end
    cdb_valid  = 2'b10;
    cdb_tag[1] = 4'd9;
    cdb_val[1] = 32'hDEAD;
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b1 || rs_data[0].rs2 !== 32'hDEAD) begin
      fail_cnt++;
      $display("FAIL wakeup_match: got v=%b rs2=%h want v=1 rs2=dead",
               rs_data[0].valid_operands, rs_data[0].rs2);
    end
    consumed_bus = 4'b0001;
    tick();
    idle();
  endtask

  task automatic test_bypass;
    set_disp(ALU_ADD, 4'd6, 1'b0, 32'd0, 4'd4, 1'b1, 32'd2, 4'd0);
    cdb_valid  = 2'b11;
    cdb_tag[0] = 4'd4;
    cdb_val[0] = 32'h11;
    cdb_tag[1] = 4'd4;
    cdb_val[1] = 32'h22;
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b1 || rs_data[0].rs1 !== 32'h11) begin
      fail_cnt++;
      $display("FAIL bypass: got v=%b rs1=%h want v=1 rs1=11",
               rs_data[0].valid_operands, rs_data[0].rs1);
    end
    consumed_bus = 4'b0001;
    tick();
    idle();
    // Waiting entry, both ports match: port 0 must win.
    set_disp(ALU_ADD, 4'd7, 1'b0, 32'd0, 4'd6, 1'b1, 32'd3, 4'd0);
    tick();
    idle();
    cdb_valid  = 2'b11;
    cdb_tag[0] = 4'd6;
    cdb_val[0] = 32'hA;
    cdb_tag[1] = 4'd6;
    cdb_val[1] = 32'hB;
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b1 || rs_data[0].rs1 !== 32'hA) begin
      fail_cnt++;
      $display("FAIL port_priority: got v=%b rs1=%h want v=1 rs1=a",
               rs_data[0].valid_operands, rs_data[0].rs1);
    end
    consumed_bus = 4'b0001;
    tick();
    idle();
  endtask

  task automatic test_consume_vs_cdb;
    set_disp(ALU_ADD, 4'd7, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd7);
    tick();
    idle();
    cdb_valid    = 2'b01;
    cdb_tag[0]   = 4'd7;
    cdb_val[0]   = 32'h55;
    consumed_bus = 4'b0001;
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b0 || disp_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL consume_wins: got v=%b rdy=%b want v=0 rdy=1",
               rs_data[0].valid_operands, disp_ready);
    end
    set_disp(ALU_ADD, 4'd8, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].ROB_entry !== 4'd8 || rs_data[0].valid_operands !== 1'b1 ||
        rs_data[1].valid_operands !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reuse_entry0: got rob0=%0d v0=%b v1=%b want rob0=8 v0=1 v1=0",
               rs_data[0].ROB_entry, rs_data[0].valid_operands, rs_data[1].valid_operands);
    end
    consumed_bus = 4'b0001;
    tick();
    idle();
  endtask

  task automatic test_full;
    reset = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_disp(ALU_ADD, 4'(10 + i), 1'b1, 32'(i), 4'd0, 1'b1, 32'd0, 4'd0);
      tick();
      idle();
    end
    test_cnt++;
    if (disp_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL full_ready: got %b want 0", disp_ready);
    end
    set_disp(ALU_SUB, 4'd15, 1'b1, 32'hFF, 4'd0, 1'b1, 32'hFF, 4'd0);
    for (int c = 0; c < 5; c++) tick();
    for (int i = 0; i < 4; i++) begin
      test_cnt++;
      if (rs_data[i].ROB_entry !== 4'(10 + i) || rs_data[i].rs1 !== 32'(i) ||
          rs_data[i].valid_operands !== 1'b1) begin
        fail_cnt++;
        $display("FAIL full_ignore%0d: got rob=%0d rs1=%0d v=%b want rob=%0d rs1=%0d v=1",
                 i, rs_data[i].ROB_entry, rs_data[i].rs1, rs_data[i].valid_operands, 10 + i, i);
      end
    end
`ifdef RS_PERF_CNT_EN
    test_cnt++;
    if (perf_full_stall !== 32'd5) begin
      fail_cnt++;
      $display("FAIL perf_stall5: got %0d want 5", perf_full_stall);
    end
`endif
    // Consume entry 2 while still dispatching: the freed slot must not be reused this cycle.
    consumed_bus = 4'b0100;
    tick();
    idle();
    test_cnt++;
    if (rs_data[2].valid_operands !== 1'b0 || disp_ready !== 1'b1 ||
        rs_data[3].ROB_entry !== 4'd13) begin
      fail_cnt++;
      $display("FAIL consume_no_reuse: got v2=%b rdy=%b rob3=%0d want v2=0 rdy=1 rob3=13",
               rs_data[2].valid_operands, disp_ready, rs_data[3].ROB_entry);
    end
`ifdef RS_PERF_CNT_EN
    test_cnt++;
    if (perf_full_stall !== 32'd6 || perf_issue !== 32'd1) begin
      fail_cnt++;
      $display("FAIL perf_after_consume: got stall=%0d issue=%0d want stall=6 issue=1",
               perf_full_stall, perf_issue);
    end
`endif
    set_disp(ALU_ADD, 4'd12, 1'b1, 32'd12, 4'd0, 1'b1, 32'd0, 4'd0);
    tick();
    idle();
    test_cnt++;
    if (rs_data[2].ROB_entry !== 4'd12 || rs_data[2].valid_operands !== 1'b1 ||
        disp_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL refill_entry2: got rob2=%0d v2=%b rdy=%b want rob2=12 v2=1 rdy=0",
               rs_data[2].ROB_entry, rs_data[2].valid_operands, disp_ready);
    end
    consumed_bus = 4'b0011;
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b0 || rs_data[1].valid_operands !== 1'b0 ||
        rs_data[2].valid_operands !== 1'b1 || disp_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL consume_two: got v=%b%b%b%b rdy=%b want v=1100 rdy=1",
               rs_data[3].valid_operands, rs_data[2].valid_operands,
               rs_data[1].valid_operands, rs_data[0].valid_operands, disp_ready);
    end
`ifdef RS_PERF_CNT_EN
    test_cnt++;
    if (perf_issue !== 32'd3) begin
      fail_cnt++;
      $display("FAIL perf_issue_add2: got %0d want 3", perf_issue);
    end
`endif
  endtask

  task automatic test_flush;
    // Entries 2 and 3 still busy; add a waiting entry 0 to make three.
    set_disp(ALU_ADD, 4'd1, 1'b0, 32'd0, 4'd5, 1'b1, 32'd0, 4'd0);
    tick();
    idle();
    flush = 1'b1;
    set_disp(ALU_ADD, 4'd9, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0);
    cdb_valid  = 2'b01;
    cdb_tag[0] = 4'd5;
    cdb_val[0] = 32'h77;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      test_cnt++;
      if (rs_data[i].valid_operands !== 1'b0 || rs_data[i].ROB_entry !== 4'd0) begin
        fail_cnt++;
        $display("FAIL flush_entry%0d: got v=%b rob=%0d want v=0 rob=0",
                 i, rs_data[i].valid_operands, rs_data[i].ROB_entry);
      end
    end
    test_cnt++;
    if (disp_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL flush_ready: got %b want 1", disp_ready);
    end
`ifdef RS_PERF_CNT_EN
    test_cnt++;
    if (perf_issue !== 32'd3 || perf_full_stall !== 32'd6) begin
      fail_cnt++;
      $display("FAIL perf_keep_on_flush: got issue=%0d stall=%0d want issue=3 stall=6",
               perf_issue, perf_full_stall);
    end
`endif
  endtask

  task automatic test_reset_mid;
    set_disp(ALU_ADD, 4'd2, 1'b1, 32'd4, 4'd0, 1'b1, 32'd4, 4'd0);
    tick();
    idle();
    reset = 1'b1;
    set_disp(ALU_ADD, 4'd3, 1'b1, 32'd4, 4'd0, 1'b1, 32'd4, 4'd0);
    tick();
    idle();
    test_cnt++;
    if (rs_data[0].valid_operands !== 1'b0 || rs_data[1].valid_operands !== 1'b0 ||
        disp_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_mid: got v0=%b v1=%b rdy=%b want v0=0 v1=0 rdy=1",
               rs_data[0].valid_operands, rs_data[1].valid_operands, disp_ready);
    end
`ifdef RS_PERF_CNT_EN
    test_cnt++;
    if (perf_issue !== 32'd0 || perf_full_stall !== 32'd0) begin
      fail_cnt++;
      $display("FAIL perf_reset: got issue=%0d stall=%0d want 0 0", perf_issue, perf_full_stall);
    end
`endif
  endtask

  initial begin
    disp_ALU_op      = '0;
    disp_load        = 1'b0;
    disp_branch_type = NB;
    disp_ROB_entry   = '0;
    disp_rs1_rdy     = 1'b0;
    disp_rs1_val     = '0;
    disp_rs1_tag     = '0;
    disp_rs2_rdy     = 1'b0;
    disp_rs2_val     = '0;
    disp_rs2_tag     = '0;
    cdb_tag          = '0;
    cdb_val          = '0;
    idle();
    test_reset();
    test_ready_dispatch();
    test_cdb_wakeup();
    test_bypass();
    test_consume_vs_cdb();
    test_full();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Four-entry reservation-station bank in the Issue stage, directly upstream of the functional-unit scheduler.
- Accepts one dispatched instruction per cycle from rename/dispatch.
- Snoops the common data bus (CDB) to capture missing operands.
- Presents each entry to the scheduler as an rs_out_t. Frees an entry when the scheduler asserts its consumed bit.

Parameters:
- NUM_CDB, 2, number of CDB broadcast ports snooped.
- TAG_W, 4, ROB tag width; must match the rs_out_t ROB_entry width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  mispredict flush; clears all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_ALU_op  in  4  operation
- disp_load  in  1  load flag
- disp_branch_type  in  3  branch_type_t
- disp_ROB_entry  in  TAG_W  destination ROB tag
- disp_rs1_rdy  in  1  rs1 value valid
- disp_rs1_val  in  32  rs1 value
- disp_rs1_tag  in  TAG_W  producing ROB tag when not ready
- disp_rs2_rdy  in  1  rs2 value valid
- disp_rs2_val  in  32  rs2 value
- disp_rs2_tag  in  TAG_W  producing ROB tag when not ready
- cdb_valid  in  NUM_CDB  broadcast valid per port
- cdb_tag  in  NUM_CDB x TAG_W  broadcast ROB tag
- cdb_val  in  NUM_CDB x 32  broadcast result
- consumed_bus  in  4  one-hot; entry issued this cycle
- rs_data  out  4 x rs_out_t  entry contents (rs0..rs3) to the scheduler

Behaviour:
- Per-entry state: busy, ALU_op, load, branch_type, ROB_entry, and for each of op1/op2 a rdy flag, a tag and a value.
- rs_data[i].valid_operands = busy & op1.rdy & op2.rdy; all other fields are driven from the registers. This path is combinational from registers only, with no input-to-output paths.
- Reset (synchronous, highest priority): all busy=0, all rdy=0, all fields 0, branch_type=NB, so valid_operands=0 on every entry. disp_ready=1 after reset. Reset mid-operation discards all entries silently.
- Flush (next priority): same clearing effect as reset. Dispatch and CDB activity in the flush cycle are ignored.
- disp_ready = ~&busy, from registered state.
- Allocation: when disp_valid & disp_ready, write the lowest-index entry with busy=0 at the clock edge. disp_valid while full is ignored and causes no state change.
- Consumed entries: an entry with consumed_bus[i]=1 clears busy at the edge. Its slot is not reusable in the same cycle, because allocation uses the pre-edge busy mask; it is free one cycle later. consumed_bus on a non-busy entry is ignored.
- CDB capture: for each busy entry and each operand with rdy=0, if cdb_valid[p] and cdb_tag[p]==tag, set rdy=1 and value=cdb_val[p] at the edge. If several ports match, the lowest p wins.
- Dispatch bypass: an operand dispatched with rdy=0 whose tag matches a valid CDB port in the same cycle is written with rdy=1 and the CDB value. Without this, the broadcast would be lost.
- Latency: a dispatch with both operands ready gives valid_operands=1 on the cycle after disp_valid. A CDB wakeup gives valid_operands=1 on the cycle after the broadcast.
- Simultaneous consumed and CDB on the same entry: consumed wins and the entry is freed.
- Operand values are unsigned 32-bit raw data with no arithmetic. Tags are compared exactly and do not wrap.

Optional Feature:
- Macro: RS_PERF_CNT_EN.
- When defined, adds output ports perf_full_stall (32-bit) and perf_issue (32-bit):
  - perf_full_stall increments each cycle in which disp_valid & ~disp_ready.
  - perf_issue increments by popcount(consumed_bus & busy).
  - Both counters wrap at 2^32 and are cleared by reset but not by flush.
- When undefined, neither the ports nor the counters exist. Functional behaviour is identical either way.

Decomposition:
- structs_pkg owns:
  - rs_out_t (existing)
  - branch_type_t / NB (existing)
  - ALU_op encodings (existing)
  - new rs_operand_t {rdy, tag, val}
  - new rs_entry_t
  - constant RS_ENTRIES=4
- One natural sub-module, rs_operand_snoop: a single-operand register with CDB match/capture and dispatch bypass, instantiated twice per entry.

Test Plan:
- Reset, then dispatch ADD with rs1=5 and rs2=7 both ready, ROB_entry=3. Next cycle rs_data[0].valid_operands=1, rs1=5, rs2=7, ROB_entry=3.
- Dispatch with rs2 not ready, tag=9; two cycles later cdb_valid[1]=1, tag=9, val=0xDEAD. valid_operands stays 0 until the cycle after the broadcast, then rs2=0xDEAD.
- Dispatch rs1 with tag=4 in the same cycle as CDB port 0 broadcasting tag=4, val=0x11. Entry holds rs1=0x11 and rdy=1 on the next cycle, with no wakeup missed.
- Fill 4 entries: disp_ready=0, and a fifth disp_valid changes nothing. Assert consumed_bus=4'b0100: disp_ready=1 next cycle, and the next dispatch lands in entry 2.
- Assert flush with 3 busy entries plus a simultaneous dispatch and CDB match. All valid_operands=0 next cycle and disp_ready=1.
- With RS_PERF_CNT_EN: 5 cycles of disp_valid while full gives perf_full_stall=5. consumed_bus=4'b0011 on two busy entries adds 2 to perf_issue.
